// File: rtl/print_pkg.sv
// Shared definitions for the print job engine: grant codes, FSM states and
// the grant-to-one-hot mapping used for the ack/done pulses.
package print_pkg;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_BOSS = 2'b01;
    localparam logic [1:0] GNT_ENG  = 2'b10;
    localparam logic [1:0] GNT_BOY  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRINT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Boss sits on bit 2, eng on bit 1, boy on bit 0; no grant maps to zero.
    function automatic logic [2:0] gnt_onehot(input logic [1:0] g);
        logic [2:0] v;
        case (g)
            GNT_BOSS: v = 3'b100;
            GNT_ENG:  v = 3'b010;
            GNT_BOY:  v = 3'b001;
            default:  v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/print_job_engine_page_timer.sv
// Page timer: counts cycles while run is high and flags the last cycle of
// every PAGE_CYCLES-long page so the engine can strobe on the next edge.
module page_timer #(
    parameter int PAGE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PAGE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Modulo-PAGE_CYCLES counter, held at zero whenever the engine is not printing.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/print_job_engine.sv
// Print job engine: accepts one arbiter grant at a time, prints the owner's
// page count at PAGE_CYCLES per page, and reports accept/done pulses plus a
// saturating count of completed jobs. All outputs are registered.
module print_job_engine
    import print_pkg::*;
#(
    parameter int PW          = 4,
    parameter int PAGE_CYCLES = 4,
    parameter int JCW         = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     grant,
    input  logic [PW-1:0]  pages_boss,
    input  logic [PW-1:0]  pages_eng,
    input  logic [PW-1:0]  pages_boy,
    output logic [2:0]     ack,
    output logic [2:0]     done,
    output logic           busy,
    output logic [1:0]     owner,
    output logic           page_strobe,
    output logic [PW-1:0]  pages_left,
    output logic [JCW-1:0] job_count
);

    state_t         state, state_n;
    logic [2:0]     ack_n, done_n;
    logic           busy_n, strobe_n;
    logic [1:0]     owner_n;
    logic [PW-1:0]  left_n, sel_pages;
    logic [JCW-1:0] count_n;
    logic           tick;

    page_timer #(.PAGE_CYCLES(PAGE_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (state == PRINT),
        .tick (tick)
    );

    // Page count of whichever requester the arbiter is currently granting.
    always_comb begin
        sel_pages = '0;
        case (grant)
            GNT_BOSS: sel_pages = pages_boss;
            GNT_ENG:  sel_pages = pages_eng;
            GNT_BOY:  sel_pages = pages_boy;
            default:  sel_pages = '0;
        endcase
    end

    // Next-state and next-output logic; pulses default low, held values default to current.
    always_comb begin
        state_n  = state;
        ack_n    = 3'b000;
        done_n   = 3'b000;
        strobe_n = 1'b0;
        busy_n   = busy;
        owner_n  = owner;
        left_n   = pages_left;
        count_n  = job_count;
        case (state)
            IDLE: begin
                if (grant != GNT_NONE) begin
                    owner_n = grant;
                    left_n  = sel_pages;
                    busy_n  = 1'b1;
                    ack_n   = gnt_onehot(grant);
                    state_n = (sel_pages != '0) ? PRINT : DONE;
                end
            end
            PRINT: begin
                if (tick && (pages_left != '0)) begin
                    strobe_n = 1'b1;
                    left_n   = pages_left - PW'(1);
                    if (pages_left == PW'(1)) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                done_n  = gnt_onehot(owner);
                busy_n  = 1'b0;
                owner_n = GNT_NONE;
                if (job_count != '1) begin
                    count_n = job_count + JCW'(1);
                end
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any job in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ack         <= 3'b000;
            done        <= 3'b000;
            busy        <= 1'b0;
            owner       <= GNT_NONE;
            page_strobe <= 1'b0;
            pages_left  <= '0;
            job_count   <= '0;
        end else begin
            state       <= state_n;
            ack         <= ack_n;
            done        <= done_n;
            busy        <= busy_n;
            owner       <= owner_n;
            page_strobe <= strobe_n;
            pages_left  <= left_n;
            job_count   <= count_n;
        end
    end

endmodule
